id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Registered RV32I decode stage: decodes inst, reads regfile, applies N-source operand bypass, resolves branches/jumps.
//  Detects load-use hazards and sits between IF and EX with valid/ready handshakes on both sides.
//  Output register gives 1-cycle latency and breaks the regfile-to-ALU combinational path.
// PARAMETERS
//  XLEN      32  data/address width
//  RA_W      5   register address width
//  NUM_FWD   2   bypass sources; index 0 = youngest (EX), highest priority
//  ALUOP_W   8   aluop width
//  ALUSEL_W  3   alusel width
// PORTS
//  clk        in   1              clock
//  rst        in   1              reset, synchronous, active-high
//  in_valid   in   1              IF presents inst
//  in_ready   out  1              stage accepts inst this cycle
//  in_pc      in   XLEN           inst address
//  in_inst    in   32             instruction word
//  re1/re2    out  1 each         regfile read enables (combinational)
//  raddr1/2   out  RA_W each      regfile read addresses (combinational)
//  rdata1/2   in   XLEN each      regfile read data, same cycle
//  fwd_we     in   NUM_FWD        bypass write enables
//  fwd_waddr  in   NUM_FWD*RA_W   bypass dest addrs, packed, source i at [i*RA_W +: RA_W]
//  fwd_wdata  in   NUM_FWD*XLEN   bypass data, packed likewise
//  ex_is_load in   1              inst currently in EX is a load
//  ex_waddr   in   RA_W           its destination
//  flush      in   1              kill in-flight/held decode
//  out_valid  out  1              decoded bundle valid
//  out_ready  in   1              EX accepts bundle
//  alusel     out  ALUSEL_W       result class
//  aluop      out  ALUOP_W        operation
//  opv1/opv2  out  XLEN each      resolved operands
//  we         out  1              dest write enable
//  waddr      out  RA_W           dest register
//  link_addr  out  XLEN           pc+4 for JAL/JALR
//  illegal    out  1              unrecognised encoding
//  br         out  1              redirect pulse
//  br_addr    out  XLEN           redirect target
// BEHAVIOUR
//  - Reset: out_valid, br, illegal, we = 0; every other registered output = 0. Reset wins over all other inputs.
//  - Accept = in_valid & in_ready. in_ready = (!out_valid | out_ready) & !stall & !flush.
//  - Latency: the bundle for an inst accepted in cycle N is on outputs in N+1 with out_valid=1.
//  - Holding: while out_valid & !out_ready, all out_* hold bit-stable. Next cycle out_valid=0 if out_ready & no accept.
//  - Operand select per source: reg addr 0 -> 0. Else lowest i with fwd_we[i] & addr match -> fwd_wdata[i]. Else rdata. Unused source -> imm.
//  - Load-use stall: re & addr!=0 & ex_is_load & ex_waddr==addr -> stall=1. No accept; a bubble is inserted when out_ready.
//  - Immediates are sign-extended to XLEN. LUI opv1=0; AUIPC opv1=pc.
//  - Shift-imm opv2 = shamt zero-extended. Arithmetic wraps mod 2^XLEN.
//  - Branch condition is evaluated on bypassed operands at accept.
//  - br is a 1-cycle pulse, registered with the bundle. br=1 for JAL, JALR, and taken B-type; br_addr = target.
//  - JALR target = (rs1+imm) with bit0 cleared.
//  - Illegal encoding: illegal=1, we=0, br=0, out_valid=1 (EX raises trap).
//  - flush: next cycle out_valid=0 and br=0, no accept. flush+accept in the same cycle -> flush wins.
//  - A second br is impossible on the cycle after br=1 because IF flushes; this is not checked.
// CONFIGURATION
//  ID_MULDIV_EN defined: OP with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//    These use alusel=EXE_RES_MULDIV and distinct aluops.
//  Undefined: those encodings give illegal=1.
// TESTING
//  addi x1,x0,5 with out_ready=1 -> next cycle out_valid=1, opv1=0, opv2=5, we=1, waddr=1, br=0.
//  add x3,x1,x2 with fwd0={1,x1,7}, fwd1={1,x1,9}, rdata2=4 -> opv1=7 (fwd0 wins), opv2=4.
//  ex_is_load=1, ex_waddr=1, in add x3,x1,x2 -> in_ready=0 for 1 cycle, bubble out_valid=0.
//    Accepted once ex_is_load drops.
//  beq x1,x2,+16 at pc=0x100, x1==x2 -> br=1 for 1 cycle, br_addr=0x110. Same with x1!=x2 -> br=0.
//  jalr x1,12(x5), x5=0x203 -> br_addr=0x20E, link_addr=pc+4, waddr=1.
//  out_ready=0 for 3 cycles then flush -> outputs stable 3 cycles, then out_valid=0. mul without ID_MULDIV_EN -> illegal=1.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// IF->ID and ID->EX handshake bundle for id_stage_pipe.
// slave = the decode stage's view, master = the surrounding pipeline's view.
interface id_stage_pipe_if #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [31:0]         in_inst;
    logic                out_valid;
    logic                out_ready;
    logic [ALUSEL_W-1:0] alusel;
    logic [ALUOP_W-1:0]  aluop;
    logic [XLEN-1:0]     opv1;
    logic [XLEN-1:0]     opv2;
    logic                we;
    logic [RA_W-1:0]     waddr;
    logic [XLEN-1:0]     link_addr;
    logic                illegal;
    logic                br;
    logic [XLEN-1:0]     br_addr;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, alusel, aluop, opv1, opv2, we, waddr,
               link_addr, illegal, br, br_addr
    );
    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, alusel, aluop, opv1, opv2, we, waddr,
               link_addr, illegal, br, br_addr
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with N-source bypass, load-use stall and branch resolution.
// Optional macro ID_MULDIV_EN adds M-extension decode (otherwise those encodings are illegal).
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    id_stage_pipe_if.slave            bus,
    output logic                      o_re1,
    output logic                      o_re2,
    output logic [RA_W-1:0]           o_raddr1,
    output logic [RA_W-1:0]           o_raddr2,
    input  logic [XLEN-1:0]           i_rdata1,
    input  logic [XLEN-1:0]           i_rdata2,
    input  logic [NUM_FWD-1:0]        i_fwd_we,
    input  logic [NUM_FWD*RA_W-1:0]   i_fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0]   i_fwd_wdata,
    input  logic                      i_ex_is_load,
    input  logic [RA_W-1:0]           i_ex_waddr,
    input  logic                      i_flush
);
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

    localparam logic [ALUSEL_W-1:0] SEL_NOP = ALUSEL_W'(0), SEL_LOGIC = ALUSEL_W'(1),
                                    SEL_SHIFT = ALUSEL_W'(2), SEL_ARITH = ALUSEL_W'(3),
                                    SEL_JUMP = ALUSEL_W'(4), SEL_MEM = ALUSEL_W'(5);
`ifdef ID_MULDIV_EN
    localparam logic [ALUSEL_W-1:0] EXE_RES_MULDIV = ALUSEL_W'(6);
`endif

    localparam logic [ALUOP_W-1:0] OP_NOP = ALUOP_W'(8'h00), OP_ADD = ALUOP_W'(8'h01),
                                   OP_SUB = ALUOP_W'(8'h02), OP_SLT = ALUOP_W'(8'h03),
                                   OP_SLTU = ALUOP_W'(8'h04), OP_AND = ALUOP_W'(8'h05),
                                   OP_OR = ALUOP_W'(8'h06), OP_XOR = ALUOP_W'(8'h07),
                                   OP_SLL = ALUOP_W'(8'h08), OP_SRL = ALUOP_W'(8'h09),
                                   OP_SRA = ALUOP_W'(8'h0A), OP_JAL = ALUOP_W'(8'h10),
                                   OP_JALR = ALUOP_W'(8'h11), OP_FENCE = ALUOP_W'(8'h50),
                                   OP_ECALL = ALUOP_W'(8'h51), OP_EBREAK = ALUOP_W'(8'h52);

    function automatic logic [ALUOP_W-1:0] op_of_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    op_of_f3 = alt ? OP_SUB : OP_ADD;
            3'd1:    op_of_f3 = OP_SLL;
            3'd2:    op_of_f3 = OP_SLT;
            3'd3:    op_of_f3 = OP_SLTU;
            3'd4:    op_of_f3 = OP_XOR;
            3'd5:    op_of_f3 = alt ? OP_SRA : OP_SRL;
            3'd6:    op_of_f3 = OP_OR;
            default: op_of_f3 = OP_AND;
        endcase
    endfunction

    function automatic logic [ALUSEL_W-1:0] sel_of_f3(input logic [2:0] f3);
        case (f3)
            3'd1, 3'd5:       sel_of_f3 = SEL_SHIFT;
            3'd4, 3'd6, 3'd7: sel_of_f3 = SEL_LOGIC;
            default:          sel_of_f3 = SEL_ARITH;
        endcase
    endfunction

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode, w_f7;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_f3     = w_inst[14:12];
    assign w_f7     = w_inst[31:25];
    assign w_imm_i  = XLEN'($signed(w_inst[31:20]));
    assign w_imm_s  = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
    assign w_imm_b  = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
    assign w_imm_u  = XLEN'($signed({w_inst[31:12], 12'b0}));
    assign w_imm_j  = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
    assign w_shamt  = XLEN'(w_inst[24:20]);

    logic                w_re1, w_re2, w_we, w_illegal, w_is_b, w_jal, w_jalr, w_lui, w_auipc, w_mem;
    logic [ALUSEL_W-1:0] w_alusel;
    logic [ALUOP_W-1:0]  w_aluop;
    logic [XLEN-1:0]     w_imm;

    always_comb begin
        w_re1 = 1'b0; w_re2 = 1'b0; w_we = 1'b0; w_illegal = 1'b0;
        w_is_b = 1'b0; w_jal = 1'b0; w_jalr = 1'b0; w_lui = 1'b0; w_auipc = 1'b0; w_mem = 1'b0;
        w_alusel = SEL_NOP; w_aluop = OP_NOP; w_imm = '0;
        case (w_opcode)
            OPC_LUI:   begin w_we = 1'b1; w_lui = 1'b1; w_imm = w_imm_u; w_alusel = SEL_ARITH; w_aluop = OP_ADD; end
            OPC_AUIPC: begin w_we = 1'b1; w_auipc = 1'b1; w_imm = w_imm_u; w_alusel = SEL_ARITH; w_aluop = OP_ADD; end
            OPC_JAL:   begin w_we = 1'b1; w_jal = 1'b1; w_imm = w_imm_j; w_alusel = SEL_JUMP; w_aluop = OP_JAL; end
            OPC_JALR: begin
                w_re1 = 1'b1; w_we = 1'b1; w_jalr = 1'b1; w_imm = w_imm_i;
                w_alusel = SEL_JUMP; w_aluop = OP_JALR; w_illegal = (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_re1 = 1'b1; w_re2 = 1'b1; w_is_b = 1'b1; w_imm = w_imm_b;
                w_aluop = ALUOP_W'({5'b00100, w_f3}); w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            OPC_LOAD: begin
                w_re1 = 1'b1; w_we = 1'b1; w_mem = 1'b1; w_imm = w_imm_i; w_alusel = SEL_MEM;
                w_aluop = ALUOP_W'({5'b00110, w_f3}); w_illegal = (w_f3 == 3'd3) || (w_f3 >= 3'd6);
            end
            // Store data travels in opv2, so the offset rides in link_addr instead.
            OPC_STORE: begin
                w_re1 = 1'b1; w_re2 = 1'b1; w_mem = 1'b1; w_imm = w_imm_s; w_alusel = SEL_MEM;
                w_aluop = ALUOP_W'({5'b00111, w_f3}); w_illegal = (w_f3 > 3'd2);
            end
            OPC_OPIMM: begin
                w_re1 = 1'b1; w_we = 1'b1; w_imm = w_imm_i;
                w_alusel = sel_of_f3(w_f3); w_aluop = op_of_f3(w_f3, 1'b0);
                if (w_f3 == 3'd1 || w_f3 == 3'd5) begin
                    w_imm     = w_shamt;
                    w_aluop   = op_of_f3(w_f3, w_f7[5]);
                    w_illegal = !((w_f7 == 7'h00) || (w_f3 == 3'd5 && w_f7 == 7'h20));
                end
            end
            OPC_OP: begin
                w_re1 = 1'b1; w_re2 = 1'b1; w_we = 1'b1;
                if (w_f7 == 7'h00) begin
                    w_alusel = sel_of_f3(w_f3); w_aluop = op_of_f3(w_f3, 1'b0);
                end else if (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
                    w_alusel = sel_of_f3(w_f3); w_aluop = op_of_f3(w_f3, 1'b1);
`ifdef ID_MULDIV_EN
                end else if (w_f7 == 7'h01) begin
                    w_alusel = EXE_RES_MULDIV; w_aluop = ALUOP_W'({5'b01000, w_f3});
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_FENCE: w_aluop = OP_FENCE;
            OPC_SYSTEM: begin
                if (w_inst[31:7] == 25'h0)          w_aluop = OP_ECALL;
                else if (w_inst[31:7] == 25'h2000)  w_aluop = OP_EBREAK;
                else                                w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_re1 = 1'b0; w_re2 = 1'b0; w_we = 1'b0; w_is_b = 1'b0; w_jal = 1'b0; w_jalr = 1'b0;
            w_alusel = SEL_NOP; w_aluop = OP_NOP;
        end
    end

    assign o_raddr1 = w_inst[15 +: RA_W];
    assign o_raddr2 = w_inst[20 +: RA_W];
    assign o_re1    = w_re1 & bus.in_valid;
    assign o_re2    = w_re2 & bus.in_valid;

    logic [NUM_FWD-1:0] w_hit1, w_hit2;
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
        assign w_hit1[gi] = i_fwd_we[gi] && (i_fwd_waddr[gi*RA_W +: RA_W] == o_raddr1);
        assign w_hit2[gi] = i_fwd_we[gi] && (i_fwd_waddr[gi*RA_W +: RA_W] == o_raddr2);
    end

    // Walk from oldest to youngest so the lowest index overrides.
    logic [XLEN-1:0] w_src1, w_src2;
    always_comb begin
        w_src1 = i_rdata1;
        w_src2 = i_rdata2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_hit1[i]) w_src1 = i_fwd_wdata[i*XLEN +: XLEN];
            if (w_hit2[i]) w_src2 = i_fwd_wdata[i*XLEN +: XLEN];
        end
        if (o_raddr1 == '0) w_src1 = '0;
        if (o_raddr2 == '0) w_src2 = '0;
    end

    logic w_taken;
    always_comb begin
        case (w_f3)
            3'd0:    w_taken = (w_src1 == w_src2);
            3'd1:    w_taken = (w_src1 != w_src2);
            3'd4:    w_taken = ($signed(w_src1) <  $signed(w_src2));
            3'd5:    w_taken = ($signed(w_src1) >= $signed(w_src2));
            3'd6:    w_taken = (w_src1 <  w_src2);
            default: w_taken = (w_src1 >= w_src2);
        endcase
    end

    logic [XLEN-1:0] w_opv1, w_opv2, w_br_addr, w_link;
    logic            w_br, w_stall, w_accept;
    assign w_opv1    = w_lui ? '0 : w_auipc ? bus.in_pc : w_re1 ? w_src1 : w_imm;
    assign w_opv2    = w_re2 ? w_src2 : w_imm;
    assign w_br      = w_jal | w_jalr | (w_is_b & w_taken);
    assign w_br_addr = w_jalr ? ((w_src1 + w_imm) & ~XLEN'(1)) : (bus.in_pc + w_imm);
    assign w_link    = w_mem ? w_imm : (bus.in_pc + XLEN'(4));

    assign w_stall = i_ex_is_load &
                     ((o_re1 && o_raddr1 != '0 && i_ex_waddr == o_raddr1) ||
                      (o_re2 && o_raddr2 != '0 && i_ex_waddr == o_raddr2));
    assign bus.in_ready = (!bus.out_valid | bus.out_ready) & !w_stall & !i_flush;
    assign w_accept     = bus.in_valid & bus.in_ready;

    logic                r_out_valid, r_we, r_illegal, r_br;
    logic [ALUSEL_W-1:0] r_alusel;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [XLEN-1:0]     r_opv1, r_opv2, r_link_addr, r_br_addr;
    logic [RA_W-1:0]     r_waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0; r_we <= 1'b0; r_illegal <= 1'b0; r_br <= 1'b0;
            r_alusel <= '0; r_aluop <= '0; r_opv1 <= '0; r_opv2 <= '0;
            r_link_addr <= '0; r_br_addr <= '0; r_waddr <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_br        <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_we        <= w_we;
            r_illegal   <= w_illegal;
            r_br        <= w_br;
            r_alusel    <= w_alusel;
            r_aluop     <= w_aluop;
            r_opv1      <= w_opv1;
            r_opv2      <= w_opv2;
            r_link_addr <= w_link;
            r_br_addr   <= w_br_addr;
            r_waddr     <= w_we ? w_inst[7 +: RA_W] : '0;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_br        <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.we        = r_we;
    assign bus.illegal   = r_illegal;
    assign bus.br        = r_br;
    assign bus.alusel    = r_alusel;
    assign bus.aluop     = r_aluop;
    assign bus.opv1      = r_opv1;
    assign bus.opv2      = r_opv2;
    assign bus.link_addr = r_link_addr;
    assign bus.br_addr   = r_br_addr;
    assign bus.waddr     = r_waddr;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions push expected bundles,
// a negedge monitor pops and compares whenever EX takes a bundle.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic        ex_is_load, flush;
    logic [4:0]  ex_waddr;
    logic [31:0] rf [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .RA_W(5), .ALUOP_W(8), .ALUSEL_W(3)) bus ();

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_re1(re1), .o_re2(re2), .o_raddr1(raddr1), .o_raddr2(raddr2),
        .i_rdata1(rdata1), .i_rdata2(rdata2),
        .i_fwd_we(fwd_we), .i_fwd_waddr(fwd_waddr), .i_fwd_wdata(fwd_wdata),
        .i_ex_is_load(ex_is_load), .i_ex_waddr(ex_waddr), .i_flush(flush)
    );

    always_comb begin
        rdata1 = rf[raddr1];
        rdata2 = rf[raddr2];
    end

    typedef struct {
        logic [31:0] pc, opv1, opv2, br_addr, link;
        logic [4:0]  waddr;
        logic        we, br, ill, chk_ops, chk_tgt;
    } exp_t;
    exp_t q[$];

    function automatic exp_t mk(input logic [31:0] pc, opv1, opv2, input logic we, input logic [4:0] waddr,
                                input logic br, input logic [31:0] br_addr, link,
                                input logic ill, chk_ops, chk_tgt);
        exp_t e;
        e.pc = pc; e.opv1 = opv1; e.opv2 = opv2; e.we = we; e.waddr = waddr; e.br = br;
        e.br_addr = br_addr; e.link = link; e.ill = ill; e.chk_ops = chk_ops; e.chk_tgt = chk_tgt;
        return e;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per bundle EX takes; br must be low whenever no bundle is valid.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_bundle: got opv1=%h want none", bus.opv1);
            end else begin
                e = q.pop_front();
                if (e.chk_ops) begin
                    chk("opv1", bus.opv1, e.opv1);
                    chk("opv2", bus.opv2, e.opv2);
                end
                chk("we", 32'(bus.we), 32'(e.we));
                chk("waddr", 32'(bus.waddr), 32'(e.waddr));
                chk("br", 32'(bus.br), 32'(e.br));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                if (e.chk_tgt) begin
                    chk("br_addr", bus.br_addr, e.br_addr);
                    chk("link_addr", bus.link_addr, e.link);
                end
                $display("txn pc=%h opv1=%h opv2=%h we=%0d waddr=%0d br=%0d br_addr=%h ill=%0d",
                         e.pc, bus.opv1, bus.opv2, bus.we, bus.waddr, bus.br, bus.br_addr, bus.illegal);
            end
        end
        if (!rst && !bus.out_valid) chk("br_idle", 32'(bus.br), 32'h0);
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e, input logic push);
        int n;
        n = 0;
        bus.in_pc = pc; bus.in_inst = inst; bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 pc=%h", pc);
            bus.in_valid = 1'b0;
            return;
        end
        if (push) q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (push) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd100; rf[2] = 32'd4; rf[5] = 32'h203;
        rst = 1'b1; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
        ex_is_load = 1'b0; ex_waddr = '0; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h0; bus.in_inst = 32'h00500093; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_br", 32'(bus.br), 32'h0);
        chk("rst_we", 32'(bus.we), 32'h0);
        chk("rst_illegal", 32'(bus.illegal), 32'h0);
        chk("rst_opv1", bus.opv1, 32'h0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // addi x1,x0,5
        issue(32'h0, 32'h00500093, mk(32'h0, 32'h0, 32'd5, 1, 5'd1, 0, 0, 32'h4, 0, 1, 0), 1);

        // add x3,x1,x2 with both bypass sources hitting x1: youngest wins
        fwd_we = 2'b11; fwd_waddr = {5'd1, 5'd1}; fwd_wdata = {32'd9, 32'd7};
        issue(32'h4, 32'h002081B3, mk(32'h4, 32'd7, 32'd4, 1, 5'd3, 0, 0, 0, 0, 1, 0), 1);
        // only the older source hits, on x2
        fwd_we = 2'b10; fwd_waddr = {5'd2, 5'd1};
        issue(32'h8, 32'h002081B3, mk(32'h8, 32'd100, 32'd9, 1, 5'd3, 0, 0, 0, 0, 1, 0), 1);
        // bypass aimed at x0 must not override the hard zero
        fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd0}; fwd_wdata = {32'd0, 32'd77};
        issue(32'hC, 32'h002001B3, mk(32'hC, 32'h0, 32'd4, 1, 5'd3, 0, 0, 0, 0, 1, 0), 1);
        fwd_we = '0;

        // load-use stall on x1
        ex_is_load = 1'b1; ex_waddr = 5'd1;
        bus.in_pc = 32'h10; bus.in_inst = 32'h002081B3; bus.in_valid = 1'b1;
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("stall_bubble", 32'(bus.out_valid), 32'h0);
        ex_is_load = 1'b0;
        issue(32'h10, 32'h002081B3, mk(32'h10, 32'd100, 32'd4, 1, 5'd3, 0, 0, 0, 0, 1, 0), 1);

        // beq x1,x2,+16 taken then not taken
        rf[1] = 32'd50; rf[2] = 32'd50;
        issue(32'h100, 32'h00208863, mk(32'h100, 32'd50, 32'd50, 0, 5'd0, 1, 32'h110, 32'h104, 0, 1, 1), 1);
        rf[2] = 32'd51;
        issue(32'h100, 32'h00208863, mk(32'h100, 32'd50, 32'd51, 0, 5'd0, 0, 32'h110, 32'h104, 0, 1, 1), 1);
        rf[1] = 32'd100; rf[2] = 32'd4;

        // jalr x1,12(x5) and jal x1,+8
        issue(32'h300, 32'h00C280E7, mk(32'h300, 32'h203, 32'd12, 1, 5'd1, 1, 32'h20E, 32'h304, 0, 1, 1), 1);
        issue(32'h500, 32'h008000EF, mk(32'h500, 32'd8, 32'd8, 1, 5'd1, 1, 32'h508, 32'h504, 0, 1, 1), 1);

        // lui x4,0x12345 ; auipc x5,1 ; srai x6,x1,3 on a negative value
        issue(32'h600, 32'h12345237, mk(32'h600, 32'h0, 32'h12345000, 1, 5'd4, 0, 0, 0, 0, 1, 0), 1);
        issue(32'h400, 32'h00001297, mk(32'h400, 32'h400, 32'h1000, 1, 5'd5, 0, 0, 0, 0, 1, 0), 1);
        rf[1] = 32'h80000000;
        issue(32'h404, 32'h4030D313, mk(32'h404, 32'h80000000, 32'd3, 1, 5'd6, 0, 0, 0, 0, 1, 0), 1);
        rf[1] = 32'd100;

        // mul x3,x1,x2
`ifdef ID_MULDIV_EN
        issue(32'h700, 32'h022081B3, mk(32'h700, 32'd100, 32'd4, 1, 5'd3, 0, 0, 0, 0, 1, 0), 1);
`else
        issue(32'h700, 32'h022081B3, mk(32'h700, 32'h0, 32'h0, 0, 5'd0, 0, 0, 0, 1, 0, 0), 1);
`endif

        // hold under back-pressure for 3 cycles, then flush the held bundle
        bus.out_ready = 1'b0;
        issue(32'h800, 32'hFFF00113, mk(32'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'h1);
            chk("hold_opv2", bus.opv2, 32'hFFFFFFFF);
            chk("hold_waddr", 32'(bus.waddr), 32'd2);
            chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b1;

        // flush beats a simultaneous accept
        flush = 1'b1; bus.in_pc = 32'h900; bus.in_inst = 32'h00500093; bus.in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("flush_no_accept", 32'(bus.out_valid), 32'h0);
        flush = 1'b0; bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
